trace_buf: RTL and testbench
============================

TRACE_BUF -- requirements
Module: trace_buf

Interface
REQ-001 SHALL have parameter AW, default 32: PC width.
REQ-002 SHALL have parameter DW, default 32: instruction word width.
REQ-003 SHALL have parameter DEPTH, default 16: entry count; power of 2, >= 2.
REQ-004 SHALL have parameter POST, default 8: entries captured after trigger; legal range 0..DEPTH-1.
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port valid_i, input, 1: one instruction retired this cycle.
REQ-008 SHALL have port pc_i, input, AW: retired PC.
REQ-009 SHALL have port ir_i, input, DW: retired instruction word.
REQ-010 SHALL have port arm_i, input, 1: clear buffer and start capture.
REQ-011 SHALL have port trig_pc_i, input, AW: trigger PC.
REQ-012 SHALL have port rd_en_i, input, 1: pop oldest entry.
REQ-013 SHALL have port rd_data_o, output, AW+DW: {pc,ir} of popped entry.
REQ-014 SHALL have port rd_valid_o, output, 1: rd_data_o valid this cycle.
REQ-015 SHALL have port state_o, output, 2: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-016 SHALL have port count_o, output, log2(DEPTH)+1: entries held.
REQ-017 SHALL have port overflow_o, output, 1: sticky, oldest entry overwritten since arm.

Function
REQ-018 SHALL store entries in a circular array of DEPTH words, AW+DW bits each; write pointer wraps DEPTH-1 -> 0.
REQ-019 IDLE: no capture, reads ignored; arm_i -> ARMED next cycle.
REQ-020 Any state with arm_i=1: next state ARMED; wr_ptr, count_o, overflow_o cleared; same-cycle valid_i and rd_en_i ignored (arm wins).
REQ-021 ARMED/POST: each valid_i writes {pc_i,ir_i} at wr_ptr, wr_ptr+1; count_o +1, saturating at DEPTH.
REQ-022 A write with count_o==DEPTH SHALL overwrite the oldest entry and set overflow_o.
REQ-023 ARMED with valid_i and pc_i==trig_pc_i: entry written, post counter loaded with POST; next state POST, or DONE if POST==0.
REQ-024 POST: each write decrements post counter; the write that brings it to 0 moves to DONE next cycle; trig_pc_i matches are ignored.
REQ-025 DONE: no capture; rd_en_i with count_o>0 SHALL present the oldest entry (rd_ptr = wr_ptr - count_o mod DEPTH) on rd_data_o with rd_valid_o=1 on the next cycle; count_o -1.
REQ-026 rd_en_i with count_o==0, or outside DONE, SHALL be ignored: rd_valid_o=0, rd_data_o held.
REQ-027 rd_valid_o SHALL be a 1-cycle pulse per accepted pop; back-to-back pops at full rate SHALL be supported.
REQ-028 Trigger compare SHALL use all AW bits, unsigned equality.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, wr_ptr=0, count_o=0, overflow_o=0, rd_valid_o=0, rd_data_o=0, post counter 0; array contents unspecified.
REQ-030 Reset asserted mid-capture or mid-readout SHALL discard all captured data; no pop completes after deassertion.

Configuration
REQ-031 With TRACE_BUF_DISPLAY_EN defined, SHALL print one simulation line per captured entry: "PC = 0x%8X, IR = 0x%8X", plus "TRIG" when the trigger entry is written; without it, no system tasks are compiled and behaviour is otherwise identical.

Verification
REQ-032 Reset 25 ns, arm, 5 retires PC 0x0..0x10, trigger PC 0x8, POST=2 -> DONE after PC 0x10; count_o=5; pops return PC 0x0,0x4,0x8,0xC,0x10 in order.
REQ-033 DEPTH=16, POST=8, 30 retires PC 0x0..0x74, trigger 0x54 -> DONE after 0x74; count_o=16; overflow_o=1; first pop PC 0x38.
REQ-034 POST=0, trigger on third retire -> DONE the next cycle; count_o=3; last pop is the trigger entry.
REQ-035 In DONE, arm_i and rd_en_i same cycle -> ARMED, count_o=0, rd_valid_o=0.
REQ-036 Reset pulsed during POST with 4 entries held -> state_o=0, count_o=0 within the reset cycle; rd_en_i after deassertion gives rd_valid_o=0.
REQ-037 Pop with count_o==0 in DONE -> rd_valid_o=0, rd_data_o unchanged.

Source files
------------

// File: rtl/trace_buf.sv
`default_nettype none
// ============================================================================
//  Module   : trace_buf
//  Purpose  : Retired-instruction trace buffer with PC trigger, post-trigger
//             capture window and in-order readout of the captured history.
//             Optional per-entry console trace: define TRACE_BUF_DISPLAY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module trace_buf #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int POST  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [AW-1:0]            pc_i,
    input  logic [DW-1:0]            ir_i,
    input  logic                     arm_i,
    input  logic [AW-1:0]            trig_pc_i,
    input  logic                     rd_en_i,
    output logic [AW+DW-1:0]         rd_data_o,
    output logic                     rd_valid_o,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int c_pw = $clog2(DEPTH);
    localparam int c_cw = c_pw + 1;
    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);
    localparam logic [c_pw-1:0] c_post = c_pw'(POST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_pw-1:0]     r_wr_ptr;
    logic [c_pw-1:0]     w_wr_ptr_nxt;
    logic [c_pw-1:0]     r_post;
    logic [c_pw-1:0]     w_post_nxt;
    logic [c_pw-1:0]     w_rd_ptr;
    logic [c_cw-1:0]     r_count;
    logic [c_cw-1:0]     w_count_nxt;
    logic                r_overflow;
    logic                w_overflow_nxt;
    logic                w_wr_en;
    logic                w_rd_en;
    logic                w_hit;
    logic [AW+DW-1:0]    r_mem [DEPTH];
    logic [AW+DW-1:0]    r_rd_data;
    logic                r_rd_valid;

    assign w_hit    = (pc_i == trig_pc_i);
    // Oldest entry sits count slots behind the write pointer (mod DEPTH).
    assign w_rd_ptr = r_wr_ptr - r_count[c_pw-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        w_post_nxt     = r_post;
        w_wr_en        = 1'b0;
        w_rd_en        = 1'b0;

        if (arm_i) begin
            // Arm has priority over any same-cycle retire or pop.
            w_state_nxt    = S_ARMED;
            w_wr_ptr_nxt   = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
            w_post_nxt     = '0;
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (valid_i) begin
                        w_wr_en = 1'b1;
                        if (w_hit) begin
                            w_post_nxt  = c_post;
                            w_state_nxt = (POST == 0) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (valid_i) begin
                        w_wr_en    = 1'b1;
                        w_post_nxt = r_post - c_pw'(1);
                        if (r_post == c_pw'(1)) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (rd_en_i && (r_count != '0)) begin
                        w_rd_en = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (w_wr_en) begin
                w_wr_ptr_nxt = r_wr_ptr + c_pw'(1);
                // A full buffer keeps its count and loses the oldest entry.
                if (r_count == c_full) begin
                    w_overflow_nxt = 1'b1;
                end else begin
                    w_count_nxt = r_count + c_cw'(1);
                end
            end

            if (w_rd_en) begin
                w_count_nxt = r_count - c_cw'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_post     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
            r_post     <= w_post_nxt;
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_rd_data <= r_mem[w_rd_ptr];
            end
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {pc_i, ir_i};
        end
    end

`ifdef TRACE_BUF_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (rst && w_wr_en) begin
            if ((r_state == S_ARMED) && w_hit) begin
                $display("PC = 0x%8X, IR = 0x%8X TRIG", pc_i, ir_i);
            end else begin
                $display("PC = 0x%8X, IR = 0x%8X", pc_i, ir_i);
            end
        end
    end
`endif

    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;
    assign state_o    = r_state;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_trace_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_buf
//  Purpose  : Three trace_buf configurations driven in parallel and compared
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trace_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, arm_i, rd_en_i;
    logic [31:0] pc_i, ir_i, trig_pc_i;

    logic [63:0] rdd0, rdd1, rdd2;
    logic        rdv0, rdv1, rdv2;
    logic [1:0]  st0, st1, st2;
    logic [4:0]  cnt0;
    logic [3:0]  cnt1;
    logic [2:0]  cnt2;
    logic        ovf0, ovf1, ovf2;

    always #5 clk = ~clk;

    trace_buf #(.AW(32), .DW(32), .DEPTH(16), .POST(8)) u_dut0 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .ir_i(ir_i),
        .arm_i(arm_i), .trig_pc_i(trig_pc_i), .rd_en_i(rd_en_i),
        .rd_data_o(rdd0), .rd_valid_o(rdv0), .state_o(st0),
        .count_o(cnt0), .overflow_o(ovf0));

    trace_buf #(.AW(32), .DW(32), .DEPTH(8), .POST(2)) u_dut1 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .ir_i(ir_i),
        .arm_i(arm_i), .trig_pc_i(trig_pc_i), .rd_en_i(rd_en_i),
        .rd_data_o(rdd1), .rd_valid_o(rdv1), .state_o(st1),
        .count_o(cnt1), .overflow_o(ovf1));

    trace_buf #(.AW(32), .DW(32), .DEPTH(4), .POST(0)) u_dut2 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .ir_i(ir_i),
        .arm_i(arm_i), .trig_pc_i(trig_pc_i), .rd_en_i(rd_en_i),
        .rd_data_o(rdd2), .rd_valid_o(rdv2), .state_o(st2),
        .count_o(cnt2), .overflow_o(ovf2));

    // Reference model: modes 0..3 = idle/armed/post/done, history as a queue.
    int          m_depth [3] = '{16, 8, 4};
    int          m_postn [3] = '{8, 2, 0};
    int          m_mode  [3];
    int          m_rem   [3];
    bit          m_ovf   [3];
    bit          m_rdv   [3];
    logic [63:0] m_rdd   [3];
    logic [63:0] m_q     [3][$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_mode[k] = 0;
            m_rem[k]  = 0;
            m_ovf[k]  = 1'b0;
            m_rdv[k]  = 1'b0;
            m_rdd[k]  = '0;
            m_q[k].delete();
        end
    endtask

    task automatic m_push(input int k, input logic [63:0] e);
        m_q[k].push_back(e);
        if (m_q[k].size() > m_depth[k]) begin
            void'(m_q[k].pop_front());
            m_ovf[k] = 1'b1;
        end
    endtask

    task automatic model_clock();
        if (!rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            m_rdv[k] = 1'b0;
            if (arm_i) begin
                m_mode[k] = 1;
                m_ovf[k]  = 1'b0;
                m_q[k].delete();
            end else if (m_mode[k] == 1) begin
                if (valid_i) begin
                    m_push(k, {pc_i, ir_i});
                    if (pc_i == trig_pc_i) begin
                        m_rem[k]  = m_postn[k];
                        m_mode[k] = (m_postn[k] == 0) ? 3 : 2;
                    end
                end
            end else if (m_mode[k] == 2) begin
                if (valid_i) begin
                    m_push(k, {pc_i, ir_i});
                    m_rem[k]--;
                    if (m_rem[k] == 0) m_mode[k] = 3;
                end
            end else if (m_mode[k] == 3) begin
                if (rd_en_i && m_q[k].size() > 0) begin
                    m_rdd[k] = m_q[k].pop_front();
                    m_rdv[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk_inst(input int k, input logic [1:0] st, input logic [63:0] cnt,
                            input logic ovf, input logic rdv, input logic [63:0] rdd);
        chk($sformatf("state%0d", k), st, m_mode[k]);
        chk($sformatf("count%0d", k), cnt, m_q[k].size());
        chk($sformatf("overflow%0d", k), ovf, m_ovf[k]);
        chk($sformatf("rd_valid%0d", k), rdv, m_rdv[k]);
        chk($sformatf("rd_data%0d", k), rdd, m_rdd[k]);
    endtask

    task automatic check_all();
        chk_inst(0, st0, cnt0, ovf0, rdv0, rdd0);
        chk_inst(1, st1, cnt1, ovf1, rdv1, rdd1);
        chk_inst(2, st2, cnt2, ovf2, rdv2, rdd2);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic retire(input logic [31:0] pc);
        valid_i = 1'b1;
        pc_i    = pc;
        ir_i    = $urandom;
        step();
        valid_i = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; arm_i = 1'b0; rd_en_i = 1'b0;
        pc_i = '0; ir_i = '0; trig_pc_i = '0;
        model_reset();
        #2 rst = 1'b0;
        #1 check_all();
        repeat (3) step();
        rst = 1'b1;

        // Five retires, trigger on 0x8; also exercises POST=0 on the 4-deep unit.
        trig_pc_i = 32'h8;
        arm_i = 1'b1; step(); arm_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            retire(32'(i * 4));
            if (i == 2) chk("r34_state", st2, 2'd3);
        end
        chk("r32_state", st1, 2'd3);
        chk("r32_count", cnt1, 4'd5);
        chk("r34_count", cnt2, 3'd3);
        rd_en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i < 5) chk("r32_pop_pc", rdd1[63:32], 32'(i * 4));
            if (i == 2) chk("r34_last_pc", rdd2[63:32], 32'h8);
            if (i == 4) chk("r37_rdv", rdv2, 1'b0);
        end
        rd_en_i = 1'b0;

        // Thirty retires into the 16-deep unit, trigger 0x54.
        trig_pc_i = 32'h54;
        arm_i = 1'b1; step(); arm_i = 1'b0;
        for (int i = 0; i < 30; i++) retire(32'(i * 4));
        chk("r33_state", st0, 2'd3);
        chk("r33_count", cnt0, 5'd16);
        chk("r33_ovf", ovf0, 1'b1);
        rd_en_i = 1'b1; step(); rd_en_i = 1'b0;
        chk("r33_first_pc", rdd0[63:32], 32'h38);

        // Arm and pop in the same cycle: arm wins.
        arm_i = 1'b1; rd_en_i = 1'b1; step(); arm_i = 1'b0; rd_en_i = 1'b0;
        chk("r35_state", st0, 2'd1);
        chk("r35_count", cnt0, 5'd0);
        chk("r35_rdv", rdv0, 1'b0);

        // Reset during POST with four entries held.
        trig_pc_i = 32'h4;
        for (int i = 0; i < 4; i++) retire(32'(i * 4));
        chk("r36_pre_state", st0, 2'd2);
        chk("r36_pre_count", cnt0, 5'd4);
        reset_pulse();
        chk("r36_state", st0, 2'd0);
        chk("r36_count", cnt0, 5'd0);
        rd_en_i = 1'b1; step(); rd_en_i = 1'b0;
        chk("r36_rdv", rdv0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) reset_pulse();
            arm_i = ($urandom_range(0, 59) == 0);
            if (arm_i) trig_pc_i = 32'($urandom_range(0, 15) * 4);
            valid_i = $urandom_range(0, 1) == 1;
            pc_i    = 32'($urandom_range(0, 15) * 4);
            ir_i    = $urandom;
            rd_en_i = $urandom_range(0, 1) == 1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
